// File: rtl/uart_echo_responder.sv
// Far-end loopback partner for a Uart8 link: received bytes are buffered in a
// small FIFO and handed back to the Uart8 transmitter, optionally XOR-masked.
module uart_echo_responder #(
  parameter int         FIFO_DEPTH    = 8,
  parameter logic [7:0] XOR_MASK      = 8'h00,
  parameter int         START_TIMEOUT = 4096
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic                          rxDone,
  input  logic                          rxErr,
  input  logic [7:0]                    rxByte,
  input  logic                          txBusy,
  input  logic                          txDone,
  output logic                          txStart,
  output logic [7:0]                    txByte,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic [7:0]                    errCount,
  output logic                          timeoutErr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(START_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t          state_q;
  state_t          state_d;
  logic            done_p0;
  logic            done_p1;
  logic            err_p0;
  logic            err_p1;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [TW-1:0]   timer;
  logic            rise_done;
  logic            rise_err;
  logic            capture;
  logic            full;
  logic            push;
  logic            drop;
  logic            load;
  logic            pop;
  logic            tmo;
  logic            unused_txdone;

  // txDone carries no information the FSM needs; txBusy falling is the cue.
  assign unused_txdone = txDone;

  // Stage p0/p1: registered copies of the Uart8 strobes for edge detection
  assign rise_done = done_p0 & ~done_p1;
  assign rise_err  = err_p0 & ~err_p1;
  assign capture   = rise_done & ~err_p0 & en;
  assign full      = (count == CW'(FIFO_DEPTH));
  assign push      = capture & (~full | pop);
  assign drop      = capture & full & ~pop;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    pop     = 1'b0;
    tmo     = 1'b0;
    case (state_q)
      IDLE: begin
        if (en && (count != '0)) begin
          load    = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (txBusy) begin
          pop     = 1'b1;
          state_d = WAIT;
        end else if (timer == TW'(START_TIMEOUT - 1)) begin
          pop     = 1'b1;
          tmo     = 1'b1;
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (!txBusy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      done_p0    <= 1'b0;
      done_p1    <= 1'b0;
      err_p0     <= 1'b0;
      err_p1     <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      timer      <= '0;
      txStart    <= 1'b0;
      txByte     <= 8'h00;
      overflow   <= 1'b0;
      errCount   <= 8'h00;
      timeoutErr <= 1'b0;
    end else begin
      state_q <= state_d;
      done_p0 <= rxDone;
      done_p1 <= done_p0;
      err_p0  <= rxErr;
      err_p1  <= err_p0;

      if (load) begin
        txStart <= 1'b1;
        txByte  <= mem[rd_ptr];
        timer   <= '0;
      end else if (state_q == START && !pop) begin
        timer <= timer + TW'(1);
      end

      if (pop) begin
        txStart <= 1'b0;
        rd_ptr  <= rd_ptr + AW'(1);
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (drop) overflow <= 1'b1;
      if (tmo) timeoutErr <= 1'b1;
      if (rise_err) errCount <= sat_inc(errCount);
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rxByte ^ XOR_MASK;
  end

endmodule

// File: tb/tb_uart_echo_responder.sv
// Scoreboard bench for uart_echo_responder: a Uart8 transmitter stand-in answers
// txStart, and a monitor matches every start against the expected echo queue.
module tb_uart_echo_responder;

  localparam int         DEPTH = 8;
  localparam logic [7:0] MASK  = 8'h5A;
  localparam int         TMO   = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b1;
  logic       rxDone = 1'b0;
  logic       rxErr = 1'b0;
  logic [7:0] rxByte = 8'h00;
  logic       txBusy = 1'b0;
  logic       txDone = 1'b0;
  logic       txStart;
  logic [7:0] txByte;
  logic [3:0] count;
  logic       overflow;
  logic [7:0] errCount;
  logic       timeoutErr;

  int checks = 0;
  int errors = 0;
  int rmode = 0;          // 0 normal, 1 slow hold, 2 never answers
  bit resp_active = 1'b0;
  logic [7:0] expq[$];

  uart_echo_responder #(
    .FIFO_DEPTH(DEPTH), .XOR_MASK(MASK), .START_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .rxDone(rxDone), .rxErr(rxErr),
    .rxByte(rxByte), .txBusy(txBusy), .txDone(txDone), .txStart(txStart),
    .txByte(txByte), .count(count), .overflow(overflow), .errCount(errCount),
    .timeoutErr(timeoutErr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: each new start must carry the oldest outstanding echo.
  logic       prev_start = 1'b0;
  logic [7:0] cur_byte = 8'h00;
  always @(negedge clk) begin
    if (txStart === 1'b1 && !prev_start) begin
      if (expq.size() == 0) begin
        chk("unexpected_start", {24'h0, txByte}, 32'hFFFF_FFFF);
      end else begin
        cur_byte = expq.pop_front();
        chk("echo_byte", {24'h0, txByte}, {24'h0, cur_byte});
      end
    end else if (txStart === 1'b1) begin
      chk("byte_stable", {24'h0, txByte}, {24'h0, cur_byte});
    end
    prev_start = (txStart === 1'b1);
  end

  // Uart8 transmitter stand-in.
  initial begin
    forever begin
      @(negedge clk);
      if (txStart === 1'b1 && rmode != 2) begin
        int hold;
        resp_active = 1'b1;
        repeat ($urandom_range(1, 6)) @(posedge clk);
        #1 txBusy = 1'b1;
        hold = (rmode == 1) ? 300 : $urandom_range(2, 10);
        repeat (hold) @(posedge clk);
        #1 txBusy = 1'b0;
        txDone = 1'b1;
        @(posedge clk);
        #1 txDone = 1'b0;
        resp_active = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic err, input bit exp_push);
    @(posedge clk);
    #1;
    rxByte = d;
    rxDone = 1'b1;
    rxErr  = err;
    if (exp_push) expq.push_back(d ^ MASK);
    repeat (2) @(posedge clk);
    #1;
    rxDone = 1'b0;
    rxErr  = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  // Sends one byte into an idle, empty responder and measures latency to
  // txStart and how many cycles txStart stays high.
  task automatic pulse_measure(input logic [7:0] d, output int lat, output int hi);
    @(posedge clk);
    #1;
    rxByte = d;
    rxDone = 1'b1;
    expq.push_back(d ^ MASK);
    lat = 0;
    while (txStart !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 2) rxDone = 1'b0;
    end
    rxDone = 1'b0;
    hi = 0;
    while (txStart === 1'b1 && hi < 100) begin
      @(posedge clk);
      #1;
      hi++;
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (!(expq.size() == 0 && count == 0 && txStart === 1'b0 &&
             txBusy === 1'b0 && !resp_active) && n < 20000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 20000) chk(name, 32'd0, 32'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int lat, hi, n;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_txStart", {31'h0, txStart}, 32'd0);
    chk("rst_txByte", {24'h0, txByte}, 32'd0);
    chk("rst_count", {28'h0, count}, 32'd0);
    chk("rst_flags", {29'h0, overflow, timeoutErr, errCount != 8'h00}, 32'd0);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    pulse_measure(8'b1000_1010, lat, hi);
    chk("latency", lat, 32'd3);
    wait_drain("drain_single");
    chk("single_count", {28'h0, count}, 32'd0);
    chk("single_ovf", {31'h0, overflow}, 32'd0);

    // Slow transmitter: ten-byte burst against an eight-entry FIFO.
    rmode = 1;
    send_byte(8'hA5, 1'b0, 1'b1);
    n = 0;
    while (txBusy !== 1'b1 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("burst_busy_seen", {31'h0, txBusy}, 32'd1);
    for (int i = 0; i < 10; i++) send_byte(8'(i), 1'b0, i < DEPTH);
    #1;
    chk("burst_count_full", {28'h0, count}, DEPTH);
    chk("burst_ovf", {31'h0, overflow}, 32'd1);
    rmode = 0;
    wait_drain("drain_burst");
    chk("burst_drained", {28'h0, count}, 32'd0);

    // Random traffic kept below the FIFO capacity.
    for (int i = 0; i < 40; i++) begin
      n = 0;
      while (expq.size() >= 7 && n < 2000) begin
        @(posedge clk);
        n++;
      end
      repeat ($urandom_range(0, 6)) @(posedge clk);
      send_byte(8'($urandom), 1'b0, 1'b1);
    end
    wait_drain("drain_random");
    chk("ovf_sticky", {31'h0, overflow}, 32'd1);

    // Framing errors.
    send_byte(8'h33, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("err_count_one", {24'h0, errCount}, 32'd1);
    chk("err_no_push", {28'h0, count}, 32'd0);
    chk("err_no_start", {31'h0, txStart}, 32'd0);
    for (int i = 0; i < 299; i++) send_byte(8'($urandom), 1'b1, 1'b0);
    #1;
    chk("err_saturate", {24'h0, errCount}, 32'hFF);

    // Disabled: no capture.
    en = 1'b0;
    send_byte(8'h44, 1'b0, 1'b0);
    #1;
    chk("en_off_count", {28'h0, count}, 32'd0);
    en = 1'b1;

    // Transmitter never answers: start attempt times out.
    chk("tmo_before", {31'h0, timeoutErr}, 32'd0);
    rmode = 2;
    pulse_measure(8'h7A, lat, hi);
    chk("tmo_start_cycles", hi, TMO);
    chk("tmo_flag", {31'h0, timeoutErr}, 32'd1);
    chk("tmo_count", {28'h0, count}, 32'd0);

    // Reset while a start is pending.
    send_byte(8'h5C, 1'b0, 1'b1);
    n = 0;
    while (txStart !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("rst_mid_start_seen", {31'h0, txStart}, 32'd1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    chk("rst2_txStart", {31'h0, txStart}, 32'd0);
    chk("rst2_count", {28'h0, count}, 32'd0);
    chk("rst2_flags", {29'h0, overflow, timeoutErr, errCount != 8'h00}, 32'd0);
    rmode = 0;
    repeat (2) @(posedge clk);
    pulse_measure(8'hC3, lat, hi);
    chk("rst2_latency", lat, 32'd3);
    wait_drain("drain_after_reset");
    chk("final_queue", expq.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
